// File: rtl/bcd_addsub_seq.sv
// -----------------------------------------------------------------------------
// bcd_addsub_seq
// Digit-serial N-digit BCD add/subtract engine with a start/done handshake.
// Processes one BCD digit per clock, LSD first. A negative difference is
// left in ten's-complement form after the first pass. A second digit-serial
// pass turns it back into a magnitude, and the sign is reported as
// minus = 4'd15.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     begin an operation (accepted only in IDLE)
//   mode      0 = a+b, 1 = a-b (latched with start)
//   a, b      packed BCD operands, digit 0 in bits [3:0] (latched with start)
//   busy      high while digits are being processed
//   done      one-cycle pulse when result/minus/overflow/err update
//   result    BCD magnitude of the last result
//   minus     4'd15 for a negative result, else 4'd0
//   overflow  carry out of the top digit on add
//   err       last operation saw an operand digit > 9
// -----------------------------------------------------------------------------
module bcd_addsub_seq #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] result,
    output logic [3:0]          minus,
    output logic                overflow,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state_q;
    logic [W-1:0]  a_q, b_q, raw_q;
    logic          mode_q, cy_q, neg_q, serr_q;
    logic [IW-1:0] idx_q;

    // Single-digit add/subtract slice. In FIX it computes 0 - raw_k - br.
    logic [3:0] x_d, y_d, dig_d;
    logic [4:0] s_d, adj_d;
    logic       cy_d, sub_d, bad_d, last_d;

    always_comb begin
        x_d    = (state_q == FIX) ? 4'd0 : a_q[3:0];
        y_d    = (state_q == FIX) ? raw_q[3:0] : b_q[3:0];
        sub_d  = (state_q == FIX) || mode_q;
        bad_d  = (a_q[3:0] > 4'd9) || (b_q[3:0] > 4'd9);
        last_d = (idx_q == IW'(DIGITS - 1));
        s_d    = 5'd0;
        adj_d  = 5'd0;
        cy_d   = 1'b0;
        dig_d  = 4'd0;
        if (sub_d) begin
            // Bit 4 is the sign of the 5-bit difference, so it is the borrow.
            s_d   = {1'b0, x_d} - {1'b0, y_d} - {4'd0, cy_q};
            cy_d  = s_d[4];
            adj_d = s_d + 5'd10;
            dig_d = cy_d ? adj_d[3:0] : s_d[3:0];
        end else begin
            s_d   = {1'b0, x_d} + {1'b0, y_d} + {4'd0, cy_q};
            cy_d  = (s_d > 5'd9);
            adj_d = s_d - 5'd10;
            dig_d = cy_d ? adj_d[3:0] : s_d[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            raw_q    <= '0;
            mode_q   <= 1'b0;
            cy_q     <= 1'b0;
            neg_q    <= 1'b0;
            serr_q   <= 1'b0;
            idx_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            minus    <= 4'd0;
            overflow <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        mode_q  <= mode;
                        cy_q    <= 1'b0;
                        neg_q   <= 1'b0;
                        serr_q  <= 1'b0;
                        idx_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    busy  <= 1'b1;
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    // New digit enters at the top so that after DIGITS shifts
                    // digit 0 sits in bits [3:0].
                    raw_q <= (raw_q >> 4) | (W'(dig_d) << (W - 4));
                    cy_q  <= cy_d;
                    idx_q <= idx_q + 1'b1;
                    if (bad_d) serr_q <= 1'b1;
                    if (last_d) begin
                        idx_q <= '0;
                        if (mode_q && cy_d) begin
                            cy_q    <= 1'b0;
                            state_q <= FIX;
                        end else begin
                            state_q <= DONE;
                        end
                    end
                end
                FIX: begin
                    busy  <= 1'b1;
                    raw_q <= (raw_q >> 4) | (W'(dig_d) << (W - 4));
                    cy_q  <= cy_d;
                    idx_q <= idx_q + 1'b1;
                    if (last_d) begin
                        idx_q   <= '0;
                        neg_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    err  <= serr_q;
                    if (serr_q) begin
                        result   <= '0;
                        minus    <= 4'd0;
                        overflow <= 1'b0;
                    end else begin
                        result   <= raw_q;
                        minus    <= neg_q ? 4'd15 : 4'd0;
                        overflow <= !mode_q && cy_q;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd_addsub_seq
// Directed bench for bcd_addsub_seq with DIGITS=4. A vector table covers the
// arithmetic cases. Hand-written sequences cover start-while-busy,
// start in the DONE cycle, and reset mid-operation.
// -----------------------------------------------------------------------------
module tb_bcd_addsub_seq;

    logic        clk = 1'b0;
    logic        rst, start, mode;
    logic [15:0] a, b;
    logic        busy, done, overflow, err;
    logic [15:0] result;
    logic [3:0]  minus;

    int compared   = 0;
    int mismatched = 0;

    bcd_addsub_seq #(.DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .minus(minus),
        .overflow(overflow), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        m;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  mn;
        logic        ov;
        logic        er;
        int          lat;
    } vec_t;

    vec_t v[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Start one operation. Scramble the operands after acceptance, then wait
    // (bounded) for done. Return the latency in cycles and the number of busy cycles.
    task automatic run_op(input logic m, input logic [15:0] aa, input logic [15:0] bb,
                          output int lat, output int bcnt);
        @(negedge clk);
        mode = m; a = aa; b = bb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 16'hFFFF; b = 16'hFFFF; mode = ~m;
        lat = 0; bcnt = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) n++;
        end
    endtask

    initial begin
        int lat, bcnt, n;
        //      m     a         b         res       mn     ov    er    lat
        v[0]  = '{1'b0, 16'h1234, 16'h5678, 16'h6912, 4'd0,  1'b0, 1'b0, 5};
        v[1]  = '{1'b0, 16'h9999, 16'h0001, 16'h0000, 4'd0,  1'b1, 1'b0, 5};
        v[2]  = '{1'b1, 16'h0500, 16'h0123, 16'h0377, 4'd0,  1'b0, 1'b0, 5};
        v[3]  = '{1'b1, 16'h0123, 16'h0500, 16'h0377, 4'd15, 1'b0, 1'b0, 9};
        v[4]  = '{1'b1, 16'h4321, 16'h4321, 16'h0000, 4'd0,  1'b0, 1'b0, 5};
        v[5]  = '{1'b1, 16'h00A0, 16'h0001, 16'h0000, 4'd0,  1'b0, 1'b1, 5};
        v[6]  = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0, 5};
        v[7]  = '{1'b0, 16'h5555, 16'h4445, 16'h0000, 4'd0,  1'b1, 1'b0, 5};
        v[8]  = '{1'b1, 16'h0000, 16'h0001, 16'h0001, 4'd15, 1'b0, 1'b0, 9};
        v[9]  = '{1'b0, 16'h0999, 16'h0001, 16'h1000, 4'd0,  1'b0, 1'b0, 5};
        v[10] = '{1'b1, 16'h1000, 16'h0001, 16'h0999, 4'd0,  1'b0, 1'b0, 5};
        v[11] = '{1'b0, 16'h00B0, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b1, 5};
        v[12] = '{1'b1, 16'h0001, 16'h9999, 16'h9998, 4'd15, 1'b0, 1'b0, 9};
        v[13] = '{1'b1, 16'h0000, 16'h00C0, 16'h0000, 4'd0,  1'b0, 1'b1, 9};

        rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        chk("reset minus", minus, 0);
        chk("reset overflow", overflow, 0);
        chk("reset err", err, 0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op(v[i].m, v[i].a, v[i].b, lat, bcnt);
            chk($sformatf("v%0d latency", i), lat, v[i].lat);
            chk($sformatf("v%0d busy cycles", i), bcnt, v[i].lat - 1);
            chk($sformatf("v%0d busy at done", i), busy, 0);
            chk($sformatf("v%0d result", i), result, v[i].res);
            chk($sformatf("v%0d minus", i), minus, v[i].mn);
            chk($sformatf("v%0d overflow", i), overflow, v[i].ov);
            chk($sformatf("v%0d err", i), err, v[i].er);
            @(posedge clk); #1;
            chk($sformatf("v%0d done pulse width", i), done, 0);
            chk($sformatf("v%0d result hold", i), result, v[i].res);
        end

        // start pulsed two cycles into an add is ignored
        @(negedge clk);
        mode = 1'b0; a = 16'h2222; b = 16'h3333; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        lat = 0;
        repeat (2) begin @(posedge clk); #1; lat++; end
        @(negedge clk); start = 1'b1; mode = 1'b1; a = 16'h9999; b = 16'h1111;
        @(posedge clk); #1; lat++; start = 1'b0;
        while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("busy-start latency", lat, 5);
        chk("busy-start result", result, 16'h5555);
        chk("busy-start minus", minus, 0);
        count_dones(12, n);
        chk("busy-start no second done", n, 0);
        chk("busy-start result kept", result, 16'h5555);

        // start held in the DONE cycle is ignored
        @(negedge clk);
        mode = 1'b0; a = 16'h0011; b = 16'h0022; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); start = 1'b1; a = 16'h1111; b = 16'h1111;
        @(posedge clk); #1; start = 1'b0;
        chk("done-cycle done", done, 1);
        chk("done-cycle result", result, 16'h0033);
        count_dones(12, n);
        chk("done-cycle start ignored", n, 0);
        chk("done-cycle busy idle", busy, 0);

        // reset three cycles into a subtract, after a negative result
        run_op(1'b1, 16'h0123, 16'h0500, lat, bcnt);
        chk("pre-reset minus", minus, 15);
        @(negedge clk);
        mode = 1'b1; a = 16'h4321; b = 16'h4321; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("mid-rst busy", busy, 0);
        chk("mid-rst done", done, 0);
        chk("mid-rst result", result, 0);
        chk("mid-rst minus", minus, 0);
        @(negedge clk); rst = 1'b0;
        count_dones(12, n);
        chk("mid-rst no done", n, 0);
        run_op(1'b0, 16'h1234, 16'h5678, lat, bcnt);
        chk("post-rst latency", lat, 5);
        chk("post-rst result", result, 16'h6912);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
